// File: rtl/rtc_pkg.sv
// rtc_pkg: BCD digit type, time limits and range check
// shared by the RTC timekeeper and its counters.
package rtc_pkg;

  typedef logic [3:0] bcd_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MAX = 12;

  // True when both digits are decimal and lo <= value <= hi.
  function automatic logic bcd_ok(
    input bcd_t dm,
    input bcd_t dl,
    input int   lo,
    input int   hi
  );
    int v;
    v = 10 * int'(dm) + int'(dl);
    return (dm <= 4'd9) && (dl <= 4'd9) &&
           (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/rtc_bcd2_cnt.sv
// rtc_bcd2_cnt: two-digit BCD counter 00..MAX, ld beats inc.
// Ports: c_clk, c_rst, inc, ld, ld_m/ld_l in; q, nx (next), wrap out.
module rtc_bcd2_cnt
  import rtc_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic       c_clk,
  input  logic       c_rst,
  input  logic       inc,
  input  logic       ld,
  input  logic [3:0] ld_m,
  input  logic [3:0] ld_l,
  output logic [3:0] q_m,
  output logic [3:0] q_l,
  output logic [3:0] nx_m,
  output logic [3:0] nx_l,
  output logic       wrap
);

  localparam bcd_t MX_M = bcd_t'(MAX / 10);
  localparam bcd_t MX_L = bcd_t'(MAX % 10);

  logic at_max;

  assign at_max = (q_m == MX_M) && (q_l == MX_L);
  assign wrap   = inc && !ld && at_max;

  always_comb begin
    nx_m = q_m;
    nx_l = q_l;
    if (ld) begin
      nx_m = ld_m;
      nx_l = ld_l;
    end else if (inc) begin
      if (at_max) begin
        nx_m = '0;
        nx_l = '0;
      end else if (q_l == 4'd9) begin
        nx_m = q_m + 4'd1;
        nx_l = '0;
      end else begin
        nx_l = q_l + 4'd1;
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      q_m <= '0;
      q_l <= '0;
    end else begin
      q_m <= nx_m;
      q_l <= nx_l;
    end
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: BCD real-time clock with set pulses, load and alarm.
// Ports: c_clk, c_rst, h/m/s, load+ld_*, al_wr+al_*; digits, pm, pulses.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter int MODE_24H = 1,
  parameter int ALARM_EN = 1
) (
  input  logic       c_clk,
  input  logic       c_rst,
  input  logic       h,
  input  logic       m,
  input  logic       s,
  input  logic       load,
  input  logic [3:0] ld_hr_m,
  input  logic [3:0] ld_hr_l,
  input  logic [3:0] ld_mn_m,
  input  logic [3:0] ld_mn_l,
  input  logic [3:0] ld_se_m,
  input  logic [3:0] ld_se_l,
  input  logic       ld_pm,
  input  logic       al_wr,
  input  logic [3:0] al_hr_m,
  input  logic [3:0] al_hr_l,
  input  logic [3:0] al_mn_m,
  input  logic [3:0] al_mn_l,
  input  logic       al_pm,
  output logic [3:0] hr_m,
  output logic [3:0] hr_l,
  output logic [3:0] mn_m,
  output logic [3:0] mn_l,
  output logic [3:0] se_m,
  output logic [3:0] se_l,
  output logic       pm,
  output logic       sec_pulse,
  output logic       load_err,
  output logic       alarm_hit
);

  localparam logic IS12 = (MODE_24H == 0);
  localparam int   HR_LO = IS12 ? 1 : 0;
  localparam int   HR_HI = IS12 ? HR12_MAX : HR24_MAX;
  localparam bcd_t RST_HM = IS12 ? 4'd1 : 4'd0;
  localparam bcd_t RST_HL = IS12 ? 4'd2 : 4'd0;
  localparam logic [23:0] PRE_TOP = 24'(CLK_DIV - 1);

  logic [23:0] pre;
  logic        tick;
  logic        ld_ok, al_ok;
  logic        do_ld, do_h, do_m, do_s, do_tick;
  logic        se_wrap, mn_wrap, hr_inc;
  logic [3:0]  se_nm, se_nl, mn_nm, mn_nl;
  logic [3:0]  hr_nm, hr_nl;
  logic        pm_n;

  assign tick = (pre == PRE_TOP);

  assign ld_ok = bcd_ok(ld_hr_m, ld_hr_l, HR_LO, HR_HI) &&
                 bcd_ok(ld_mn_m, ld_mn_l, 0, MIN_MAX) &&
                 bcd_ok(ld_se_m, ld_se_l, 0, SEC_MAX);
  assign al_ok = bcd_ok(al_hr_m, al_hr_l, HR_LO, HR_HI) &&
                 bcd_ok(al_mn_m, al_mn_l, 0, MIN_MAX);

  // One event per cycle; a rejected load still owns its cycle.
  assign do_ld   = load && ld_ok;
  assign do_h    = !load && h;
  assign do_m    = !load && !h && m;
  assign do_s    = !load && !h && !m && s;
  assign do_tick = !load && !h && !m && !s && tick;

  rtc_bcd2_cnt #(.MAX(SEC_MAX)) u_sec (
    .c_clk (c_clk),
    .c_rst (c_rst),
    .inc   (do_s || do_tick),
    .ld    (do_ld),
    .ld_m  (ld_se_m),
    .ld_l  (ld_se_l),
    .q_m   (se_m),
    .q_l   (se_l),
    .nx_m  (se_nm),
    .nx_l  (se_nl),
    .wrap  (se_wrap)
  );

  rtc_bcd2_cnt #(.MAX(MIN_MAX)) u_min (
    .c_clk (c_clk),
    .c_rst (c_rst),
    .inc   (do_m || (do_tick && se_wrap)),
    .ld    (do_ld),
    .ld_m  (ld_mn_m),
    .ld_l  (ld_mn_l),
    .q_m   (mn_m),
    .q_l   (mn_l),
    .nx_m  (mn_nm),
    .nx_l  (mn_nl),
    .wrap  (mn_wrap)
  );

  assign hr_inc = do_h || (do_tick && se_wrap && mn_wrap);

  always_comb begin
    hr_nm = hr_m;
    hr_nl = hr_l;
    pm_n  = pm;
    if (do_ld) begin
      hr_nm = ld_hr_m;
      hr_nl = ld_hr_l;
      pm_n  = ld_pm && IS12;
    end else if (hr_inc) begin
      if (IS12 && {hr_m, hr_l} == 8'h12) begin
        hr_nm = 4'd0;
        hr_nl = 4'd1;
      end else if (IS12 && {hr_m, hr_l} == 8'h11) begin
        hr_nm = 4'd1;
        hr_nl = 4'd2;
        pm_n  = !pm;
      end else if (!IS12 && {hr_m, hr_l} == 8'h23) begin
        hr_nm = 4'd0;
        hr_nl = 4'd0;
      end else if (hr_l == 4'd9) begin
        hr_nm = hr_m + 4'd1;
        hr_nl = 4'd0;
      end else begin
        hr_nl = hr_l + 4'd1;
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      pre       <= '0;
      hr_m      <= RST_HM;
      hr_l      <= RST_HL;
      pm        <= 1'b0;
      sec_pulse <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      if (do_ld || do_s || tick)
        pre <= '0;
      else
        pre <= pre + 24'd1;
      hr_m      <= hr_nm;
      hr_l      <= hr_nl;
      pm        <= pm_n;
      sec_pulse <= do_tick;
      load_err  <= (load && !ld_ok) || (al_wr && !al_ok);
    end
  end

  if (ALARM_EN != 0) begin : g_alarm
    logic [3:0]  a_hm, a_hl, a_mm, a_ml;
    logic        a_pm, armed, hit_n;
    logic [24:0] t_now, t_nxt, t_al;

    assign t_now = {hr_m, hr_l, mn_m, mn_l, se_m, se_l, pm};
    assign t_nxt = {hr_nm, hr_nl, mn_nm, mn_nl,
                    se_nm, se_nl, pm_n};
    assign t_al  = {a_hm, a_hl, a_mm, a_ml, 8'h00, a_pm};

    // Fire only on the transition into the alarm time.
    assign hit_n = armed && (t_nxt != t_now) &&
                   (t_nxt == t_al);

    always_ff @(posedge c_clk) begin
      if (c_rst) begin
        a_hm      <= RST_HM;
        a_hl      <= RST_HL;
        a_mm      <= 4'd0;
        a_ml      <= 4'd0;
        a_pm      <= 1'b0;
        armed     <= 1'b0;
        alarm_hit <= 1'b0;
      end else begin
        alarm_hit <= hit_n;
        if (al_wr && al_ok) begin
          a_hm  <= al_hr_m;
          a_hl  <= al_hr_l;
          a_mm  <= al_mn_m;
          a_ml  <= al_mn_l;
          a_pm  <= al_pm && IS12;
          armed <= 1'b1;
        end
      end
    end
  end else begin : g_no_alarm
    assign alarm_hit = 1'b0;
  end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: directed vectors into three configurations
// (24h, 12h, 24h/div4); a negedge monitor pops expected outputs.
module tb_rtc_timekeeper;

  logic c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  logic        c_rst, h, m, s, load, ld_pm, al_wr, al_pm;
  logic [23:0] ld_t;
  logic [15:0] al_t;

  logic [3:0] hrm[3], hrl[3], mnm[3], mnl[3], sem[3], sel[3];
  logic       pm_o[3], sp_o[3], le_o[3], ah_o[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rtc_timekeeper #(
      .CLK_DIV  (g == 2 ? 4 : 1),
      .MODE_24H (g == 1 ? 0 : 1),
      .ALARM_EN (1)
    ) u_dut (
      .c_clk     (c_clk),
      .c_rst     (c_rst),
      .h         (h),
      .m         (m),
      .s         (s),
      .load      (load),
      .ld_hr_m   (ld_t[23:20]),
      .ld_hr_l   (ld_t[19:16]),
      .ld_mn_m   (ld_t[15:12]),
      .ld_mn_l   (ld_t[11:8]),
      .ld_se_m   (ld_t[7:4]),
      .ld_se_l   (ld_t[3:0]),
      .ld_pm     (ld_pm),
      .al_wr     (al_wr),
      .al_hr_m   (al_t[15:12]),
      .al_hr_l   (al_t[11:8]),
      .al_mn_m   (al_t[7:4]),
      .al_mn_l   (al_t[3:0]),
      .al_pm     (al_pm),
      .hr_m      (hrm[g]),
      .hr_l      (hrl[g]),
      .mn_m      (mnm[g]),
      .mn_l      (mnl[g]),
      .se_m      (sem[g]),
      .se_l      (sel[g]),
      .pm        (pm_o[g]),
      .sec_pulse (sp_o[g]),
      .load_err  (le_o[g]),
      .alarm_hit (ah_o[g])
    );
  end

  typedef struct {
    int          due;
    int          d;
    string       nm;
    logic [27:0] v;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge c_clk) cyc <= cyc + 1;

  function automatic logic [27:0] got(int d);
    return {hrm[d], hrl[d], mnm[d], mnl[d], sem[d], sel[d],
            pm_o[d], sp_o[d], le_o[d], ah_o[d]};
  endfunction

  function automatic logic [23:0] mk(int hh, int mm, int ss);
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10),
            4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Expected state after the coming edge.
  task automatic ex(int d, string nm, logic [23:0] t,
                    logic p, logic sp, logic le, logic ah);
    exp_t x;
    x.due = cyc + 1;
    x.d   = d;
    x.nm  = nm;
    x.v   = {t, p, sp, le, ah};
    sbq.push_back(x);
  endtask

  task automatic nxt();
    @(negedge c_clk);
    c_rst = 1'b0;
    h     = 1'b0;
    m     = 1'b0;
    s     = 1'b0;
    load  = 1'b0;
    al_wr = 1'b0;
  endtask

  task automatic ld(logic [23:0] t, logic p);
    load  = 1'b1;
    ld_t  = t;
    ld_pm = p;
  endtask

  task automatic al(logic [15:0] a, logic p);
    al_wr = 1'b1;
    al_t  = a;
    al_pm = p;
  endtask

  always @(negedge c_clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      n_chk++;
      if (got(e.d) === e.v)
        n_pass++;
      else
        $display(
          "FAIL %s dut%0d cyc%0d: got t=%h pm%b sp%b le%b ah%b want t=%h pm%b sp%b le%b ah%b",
          e.nm, e.d, cyc, got(e.d) >> 4, got(e.d) >> 3 & 1'b1,
          got(e.d) >> 2 & 1'b1, got(e.d) >> 1 & 1'b1,
          got(e.d) & 1'b1, e.v[27:4], e.v[3], e.v[2],
          e.v[1], e.v[0]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pre4, sec4;
    logic sp4, sk;
    c_rst = 1'b1;
    h = 1'b0; m = 1'b0; s = 1'b0;
    load = 1'b0; al_wr = 1'b0;
    ld_t = '0; al_t = '0; ld_pm = 1'b0; al_pm = 1'b0;
    repeat (2) @(negedge c_clk);

    c_rst = 1'b1;
    ex(0, "rst24", 24'h000000, 0, 0, 0, 0);
    ex(1, "rst12", 24'h120000, 0, 0, 0, 0);
    ex(2, "rst_div4", 24'h000000, 0, 0, 0, 0);
    nxt();
    ex(0, "run24", 24'h000001, 0, 1, 0, 0);
    ex(1, "run12", 24'h120001, 0, 1, 0, 0);
    nxt();

    ld(24'h235958, 0);
    ex(0, "ld235958", 24'h235958, 0, 0, 0, 0);
    nxt();
    ex(0, "tick235959", 24'h235959, 0, 1, 0, 0);
    nxt();
    ex(0, "wrap_day", 24'h000000, 0, 1, 0, 0);
    nxt();

    ld(24'h235959, 0);
    ex(0, "ld235959", 24'h235959, 0, 0, 0, 0);
    nxt();
    h = 1'b1;
    ex(0, "h_only", 24'h005959, 0, 0, 0, 0);
    nxt();
    m = 1'b1;
    ex(0, "m_nocarry", 24'h000059, 0, 0, 0, 0);
    nxt();
    s = 1'b1;
    ex(0, "s_nocarry", 24'h000000, 0, 0, 0, 0);
    nxt();
    ex(0, "tick_after_s", 24'h000001, 0, 1, 0, 0);
    nxt();
    ld(24'h101010, 0);
    ex(0, "ld101010", 24'h101010, 0, 0, 0, 0);
    nxt();
    h = 1'b1; m = 1'b1; s = 1'b1;
    ex(0, "prio_h", 24'h111010, 0, 0, 0, 0);
    nxt();
    ld(24'h205000, 0); h = 1'b1;
    ex(0, "prio_ld", 24'h205000, 0, 0, 0, 0);
    nxt();

    ld(24'h100000, 0);
    ex(0, "ld100000", 24'h100000, 0, 0, 0, 0);
    nxt();
    ld(24'h240000, 0);
    ex(0, "bad_hr24", 24'h100000, 0, 0, 1, 0);
    nxt();
    ex(0, "after_bad", 24'h100001, 0, 1, 0, 0);
    nxt();
    ld(24'h12345A, 0);
    ex(0, "bad_digit", 24'h100001, 0, 0, 1, 0);
    nxt();
    ex(0, "after_bad2", 24'h100002, 0, 1, 0, 0);
    nxt();
    ld(24'h006000, 0);
    ex(0, "bad_min60", 24'h100002, 0, 0, 1, 0);
    nxt();

    al(16'h0730, 0); ld(24'h072959, 0);
    ex(0, "al_pre", 24'h072959, 0, 0, 0, 0);
    ex(1, "al12_pre", 24'h072959, 0, 0, 0, 0);
    nxt();
    ex(0, "al_hit", 24'h073000, 0, 1, 0, 1);
    ex(1, "al12_hit", 24'h073000, 0, 1, 0, 1);
    nxt();
    for (int k = 1; k <= 60; k++) begin
      ex(0, "no_rehit", mk(7, 30 + k / 60, k % 60), 0, 1, 0, 0);
      nxt();
    end

    al(16'h0815, 0); ld(24'h081400, 0);
    ex(0, "al2_pre", 24'h081400, 0, 0, 0, 0);
    nxt();
    m = 1'b1;
    ex(0, "al_by_m", 24'h081500, 0, 0, 0, 1);
    nxt();
    ex(0, "al_once", 24'h081501, 0, 1, 0, 0);
    nxt();
    al(16'h2400, 0); ld(24'h081400, 0);
    ex(0, "bad_al", 24'h081400, 0, 0, 1, 0);
    nxt();
    m = 1'b1;
    ex(0, "al_kept", 24'h081500, 0, 0, 0, 1);
    nxt();
    al(16'h0815, 0); s = 1'b1;
    ex(0, "al_wr_match", 24'h081501, 0, 0, 0, 0);
    nxt();
    ld(24'h081459, 0);
    ex(0, "al3_pre", 24'h081459, 0, 0, 0, 0);
    nxt();
    ex(0, "al_reached", 24'h081500, 0, 1, 0, 1);
    nxt();

    ld(24'h235959, 0);
    ex(0, "pre_rst", 24'h235959, 0, 0, 0, 0);
    nxt();
    c_rst = 1'b1; ld(24'h240000, 0); h = 1'b1;
    ex(0, "rst_wins", 24'h000000, 0, 0, 0, 0);
    ex(1, "rst_wins12", 24'h120000, 0, 0, 0, 0);
    ex(2, "rst_div4b", 24'h000000, 0, 0, 0, 0);
    nxt();
    pre4 = 0;
    sec4 = 0;
    for (int k = 1; k <= 24; k++) begin
      sk = (k == 16 || k == 19);
      s = sk;
      if (sk) begin
        sec4++; pre4 = 0; sp4 = 1'b0;
      end else if (pre4 == 3) begin
        sec4++; pre4 = 0; sp4 = 1'b1;
      end else begin
        pre4++; sp4 = 1'b0;
      end
      if (k == 1)
        ex(0, "rst_run", 24'h000001, 0, 1, 0, 0);
      ex(2, "div4", mk(0, 0, sec4), 0, sp4, 0, 0);
      nxt();
    end

    ld(24'h115959, 0);
    ex(1, "ld12_1159", 24'h115959, 0, 0, 0, 0);
    nxt();
    ex(1, "to_12pm", 24'h120000, 1, 1, 0, 0);
    nxt();
    ld(24'h125959, 1);
    ex(1, "ld12_1259", 24'h125959, 1, 0, 0, 0);
    ex(0, "pm24_zero", 24'h125959, 0, 0, 0, 0);
    nxt();
    ex(1, "to_01pm", 24'h010000, 1, 1, 0, 0);
    nxt();
    ld(24'h110000, 1);
    ex(1, "ld12_11pm", 24'h110000, 1, 0, 0, 0);
    nxt();
    h = 1'b1;
    ex(1, "h_11_12", 24'h120000, 0, 0, 0, 0);
    nxt();
    h = 1'b1;
    ex(1, "h_12_01", 24'h010000, 0, 0, 0, 0);
    nxt();
    ld(24'h000000, 0);
    ex(1, "bad_hr12", 24'h010000, 0, 0, 1, 0);
    ex(0, "ok_hr24", 24'h000000, 0, 0, 0, 0);
    nxt();
    ex(1, "after_bad12", 24'h010001, 0, 1, 0, 0);
    nxt();
    ld(24'h095959, 1);
    ex(1, "ld12_0959", 24'h095959, 1, 0, 0, 0);
    nxt();
    ex(1, "hr_09_10", 24'h100000, 1, 1, 0, 0);
    nxt();

    nxt();
    nxt();
    n_chk++;
    if (sbq.size() == 0)
      n_pass++;
    else
      $display("FAIL sb_drain: got %0d left, want 0", sbq.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
